// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction controller and the datapath it drives.
package cpu_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    CL_MOV_IMM, CL_MOV_REG, CL_ADD, CL_CMP, CL_AND, CL_MVN, CL_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
    op_class_t cl;
    cl = CL_ILLEGAL;
    if (opcode == OPC_MOV && op == OP_MOV_IMM) cl = CL_MOV_IMM;
    else if (opcode == OPC_MOV && op == OP_MOV_REG) cl = CL_MOV_REG;
    else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cl = CL_ADD;
        OP_CMP:  cl = CL_CMP;
        OP_AND:  cl = CL_AND;
        default: cl = CL_MVN;
      endcase
    end
    return cl;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure field extraction and classification of the instruction register.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rm,
  output logic [1:0]  o_sh,
  output op_class_t   o_class,
  output logic [15:0] o_imm_sx
);

  // Field slicing, class lookup and sign extension of imm8
  always_comb begin
    o_rn     = i_ir[10:8];
    o_rd     = i_ir[7:5];
    o_sh     = i_ir[4:3];
    o_rm     = i_ir[2:0];
    o_class  = classify(i_ir[15:13], i_ir[12:11]);
    o_imm_sx = {{8{i_ir[7]}}, i_ir[7:0]};
  end

endmodule

// File: rtl/instr_controller.sv
// Instruction register plus multi-cycle control FSM driving the datapath.
//
// state       | meaning
// WAIT        | idle, w=1, IR loadable, waiting for s
// DECODE      | classify IR, no strobes
// WRITE_IMM   | write sign-extended imm8 into Rn
// GET_A       | read Rn into A
// GET_B       | read Rm into B
// ALU         | compute into C, or status only for CMP
// WRITE_REG   | write C into Rd
module instr_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;
  logic [2:0]  w_rn, w_rd, w_rm;
  logic [1:0]  w_sh;
  op_class_t   w_class;
  logic [15:0] w_imm_sx;

  instr_decoder u_dec (
    .i_ir     (r_ir),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_sh     (w_sh),
    .o_class  (w_class),
    .o_imm_sx (w_imm_sx)
  );

  // State register and IR; IR only accepts new words while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && load) r_ir <= in;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   if (s) w_next = S_DECODE;
      S_DECODE: begin
        case (w_class)
          CL_MOV_IMM:         w_next = S_WRITE_IMM;
          CL_MOV_REG, CL_MVN: w_next = S_GET_B;
          CL_ADD, CL_CMP, CL_AND: w_next = S_GET_A;
          default:            w_next = S_WAIT;
        endcase
      end
      S_WRITE_IMM: w_next = S_WAIT;
      S_GET_A:     w_next = S_GET_B;
      S_GET_B:     w_next = S_ALU;
      S_ALU:       w_next = (w_class == CL_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next = S_WAIT;
      default:     w_next = S_WAIT;
    endcase
  end

  // Moore outputs; reset overrides everything so no partial write-back escapes
  always_comb begin
    w           = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    vsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = SH_NONE;
    ALUop       = ALU_ADD;
    datapath_in = w_imm_sx;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = w_sh;
        case (w_class)
          CL_CMP:     ALUop = ALU_CMP;
          CL_AND:     ALUop = ALU_AND;
          CL_MVN:     ALUop = ALU_MVN;
          default:    ALUop = ALU_ADD;
        endcase
        asel  = (w_class == CL_MOV_REG);
        loads = (w_class == CL_CMP);
        loadc = (w_class != CL_CMP);
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      w        = 1'b1;
      readnum  = 3'd0;
      writenum = 3'd0;
      vsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      asel     = 1'b0;
      shift    = SH_NONE;
      ALUop    = ALU_ADD;
    end
  end

endmodule

// File: doc/instr_controller.md
# instr_controller

Instruction register, decoder and control FSM that sits directly upstream of `datapath`. It latches a 16-bit instruction, sequences it over several cycles, and drives every `datapath` control input (register numbers, load enables, operand selects, shift, ALU op, write-back) plus `datapath_in` (the sign-extended immediate). It signals idle/ready to the surrounding CPU through `w`.

## Interface
- No parameters. Widths are fixed by `datapath`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s` in 1: start. Sampled only in WAIT.
- `load` in 1: instruction-register load enable. Honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: high exactly when the FSM is in WAIT.
- `readnum` out 3, `writenum` out 3: register-file addresses.
- `vsel` out 1: write-back source select; 1 = `datapath_in`, 0 = C register.
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1 each: datapath strobes.
- `asel` out 1: 1 forces ALU operand A to zero.
- `bsel` out 1: held 0.
- `shift` out 2, `ALUop` out 2: shifter and ALU controls.
- `datapath_in` out 16: sign-extended IR[7:0].

## Operation
- IR fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5]
  - sh = IR[4:3], Rm = IR[2:0]
  - imm8 = IR[7:0]
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - Anything else is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- WAIT:
  - `w`=1.
  - If `load`=1, IR <= `in`.
  - If `s`=1, next state is DECODE. If `s` and `load` are both high in the same cycle, the newly loaded IR is the one executed.
- DECODE (no strobes), next state:
  - MOV imm -> WRITE_IMM
  - MOV reg, MVN -> GET_B
  - ADD, CMP, AND -> GET_A
  - illegal -> WAIT, no side effects.
- WRITE_IMM: `writenum`=Rn, `vsel`=1, `write`=1 -> WAIT.
- GET_A: `readnum`=Rn, `loada`=1 -> GET_B.
- GET_B: `readnum`=Rm, `loadb`=1 -> ALU.
- ALU:
  - `shift`=sh.
  - `ALUop`: ADD=00, CMP=01, AND=10, MVN=11, MOV reg=00 with `asel`=1.
  - Non-CMP: `loadc`=1 -> WRITE_REG.
  - CMP: `loads`=1, `loadc`=0 -> WAIT.
- WRITE_REG: `writenum`=Rd, `vsel`=0, `write`=1 -> WAIT.
- Outputs are Moore, decoded from state and IR. Any output not listed for the current state is 0, except `datapath_in`, which always reflects IR.
- `datapath_in` = {{8{IR[7]}}, IR[7:0]}.

## Timing
- Reset: state <= WAIT, IR <= 0.
  - While `reset`=1, all strobes, `shift`, `ALUop`, `readnum` and `writenum` are forced to 0 and `w`=1, including mid-instruction. No partial write-back occurs.
- Cycles spent outside WAIT, counted from the edge that samples `s`:
  - MOV imm: 2
  - MOV reg, MVN, CMP: 4
  - ADD, AND: 5
  - illegal: 1
- `w` falls in the cycle after `s` is sampled and rises in the cycle after the last active state.
- `s` and `load` are ignored outside WAIT; IR is stable for the entire instruction.
- Each strobe is high for exactly one cycle per instruction. There is no back-to-back overlap between instructions.

## Structure
- Package `cpu_pkg` holds:
  - opcode/op constants
  - state encoding
  - ALUop and shift encodings, shared with `datapath`
- One combinational sub-module, `instr_decoder`: IR -> Rn, Rd, Rm, sh, op class, `datapath_in`. The FSM and IR live in `instr_controller`.

## Test plan
- Reset, then `load`+`s` with `in`=0xD007 (MOV R0,#7):
  - `w`=0 for 2 cycles.
  - WRITE_IMM cycle shows `writenum`=0, `vsel`=1, `write`=1, `datapath_in`=0x0007.
- `in`=0xD1FE (MOV R1,#-2): `datapath_in`=0xFFFE, `writenum`=1.
- `in`=0xA148 (ADD R2,R1,R0,LSL#1), checking the per-cycle sequence:
  - GET_A: `readnum`=1, `loada`
  - GET_B: `readnum`=0, `loadb`
  - ALU: `shift`=01, `ALUop`=00, `loadc`
  - WRITE_REG: `writenum`=2, `vsel`=0, `write`
  - `w` back high after 5 cycles.
- `in`=0xA800 (CMP R0,R0):
  - `loads`=1 and `ALUop`=01 in ALU; `loadc`=0.
  - No `write` in any cycle; 4 cycles total.
- `in`=0x0000 (illegal): `w` low 1 cycle, no strobes. Pulsing `load` with 0xFFFF mid-ADD leaves IR unchanged.
- Assert `reset` in the ALU state of an ADD: all strobes 0 that cycle, WAIT next cycle, `write` never asserted.
